// File: rtl/yaw_pkg.sv
// Shared types, widths and helpers for the gyro yaw integrator.
// Provides the FSM state type, accumulator geometry and the 17->16 bit saturator.
package yaw_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAL,
        RUN
    } yaw_state_t;

    localparam int ACC_W      = 27;
    localparam int FUSION_INC = 512;
    localparam int HEAD_MSB   = 26;
    localparam int HEAD_LSB   = 15;

    // Clamp a 17-bit signed difference into the 16-bit signed range.
    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        if (v[16] != v[15]) begin
            return v[16] ? 16'sh8000 : 16'sh7FFF;
        end
        return v[15:0];
    endfunction

endpackage

// File: rtl/yaw_integrator.sv
// Turns gyro Z-rate samples into a 12-bit heading: zero-rate calibration,
// offset-corrected integration while moving, and guard-rail IR nudges.
module yaw_integrator
    import yaw_pkg::*;
#(
    parameter bit FAST_SIM = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strt_cal,
    input  logic        vld,
    input  logic [15:0] yaw_rt,
    input  logic        moving,
    input  logic        lftIR,
    input  logic        rghtIR,
    output logic        cal_done,
    output logic        rdy,
    output logic [11:0] heading
);

    localparam int CAL_LOG = FAST_SIM ? 8 : 11;
    localparam int CNT_W   = 12;
    localparam logic [CNT_W-1:0] CAL_LAST = CNT_W'((1 << CAL_LOG) - 1);

    yaw_state_t state, state_nxt;

    logic signed [ACC_W-1:0] cal_acc;
    logic        [CNT_W-1:0] cal_cnt;
    logic signed [15:0]      offset;
    logic signed [ACC_W-1:0] heading_acc;

    logic cal_clear, cal_step, cal_last, run_step;

    logic signed [ACC_W-1:0] cal_sum;
    logic signed [16:0]      yaw_diff;
    logic signed [15:0]      yaw_comp;
    logic signed [ACC_W-1:0] rate_term;
    logic signed [ACC_W-1:0] fusion_term;
    logic signed [ACC_W-1:0] heading_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A calibration request overrides everything, including a coincident sample.
    always_comb begin
        state_nxt = state;
        cal_clear = 1'b0;
        cal_step  = 1'b0;
        cal_last  = 1'b0;
        run_step  = 1'b0;
        if (strt_cal) begin
            state_nxt = CAL;
            cal_clear = 1'b1;
        end else begin
            case (state)
                IDLE: ;
                CAL: begin
                    if (vld) begin
                        cal_step = 1'b1;
                        if (cal_cnt == CAL_LAST) begin
                            cal_last  = 1'b1;
                            state_nxt = RUN;
                        end
                    end
                end
                RUN: begin
                    run_step = vld;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        cal_sum   = cal_acc + {{(ACC_W-16){yaw_rt[15]}}, yaw_rt};
        yaw_diff  = {yaw_rt[15], yaw_rt} - {offset[15], offset};
        yaw_comp  = sat16(yaw_diff);
        rate_term = moving ? {{(ACC_W-16){yaw_comp[15]}}, yaw_comp} : '0;
        if (lftIR && !rghtIR) begin
            fusion_term = ACC_W'(FUSION_INC);
        end else if (rghtIR && !lftIR) begin
            fusion_term = ACC_W'(-FUSION_INC);
        end else begin
            fusion_term = '0;
        end
        heading_sum = heading_acc + rate_term + fusion_term;
    end

    // Offset is the floor of the sample mean; heading_acc wraps freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            cal_acc     <= '0;
            cal_cnt     <= '0;
            offset      <= '0;
            heading_acc <= '0;
            cal_done    <= 1'b0;
            rdy         <= 1'b0;
        end else begin
            cal_done <= cal_last;
            rdy      <= run_step;
            if (cal_clear) begin
                cal_acc     <= '0;
                cal_cnt     <= '0;
                heading_acc <= '0;
            end
            if (cal_step) begin
                cal_acc <= cal_sum;
                cal_cnt <= cal_cnt + 1'b1;
            end
            if (cal_last) begin
                offset <= 16'(cal_sum >>> CAL_LOG);
            end
            if (run_step) begin
                heading_acc <= heading_sum;
            end
        end
    end

    assign heading = heading_acc[HEAD_MSB:HEAD_LSB];

endmodule

// File: tb/tb_yaw_integrator.sv
// Directed bench for yaw_integrator: an integer-arithmetic model checked every
// cycle, plus literal heading/cal_done expectations at key points.
module tb_yaw_integrator;

    localparam int    N_CAL = 256;
    localparam longint MOD  = 64'd134217728;

    logic        clk = 1'b0;
    logic        rst;
    logic        strt_cal;
    logic        vld;
    logic [15:0] yaw_rt;
    logic        moving;
    logic        lftIR;
    logic        rghtIR;
    logic        cal_done;
    logic        rdy;
    logic [11:0] heading;

    int checks = 0;
    int errors = 0;

    int     mode = 0;
    longint cal_sum = 0;
    int     cal_n = 0;
    int     m_offset = 0;
    longint m_acc = 0;
    int     exp_cal_done = 0;
    int     exp_rdy = 0;
    int     exp_heading = 0;
    bit     model_valid = 1'b0;

    always #5 clk = ~clk;

    yaw_integrator #(.FAST_SIM(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .strt_cal (strt_cal),
        .vld      (vld),
        .yaw_rt   (yaw_rt),
        .moving   (moving),
        .lftIR    (lftIR),
        .rghtIR   (rghtIR),
        .cal_done (cal_done),
        .rdy      (rdy),
        .heading  (heading)
    );

    function automatic int floor_div(input longint a, input longint n);
        longint q;
        q = a / n;
        if ((a % n != 0) && (a < 0)) q = q - 1;
        return int'(q);
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [15:0] y, input logic mv,
                                  input logic l, input logic r, input logic s);
        @(negedge clk);
        vld      = v;
        yaw_rt   = y;
        moving   = mv;
        lftIR    = l;
        rghtIR   = r;
        strt_cal = s;
    endtask

    // Model: mode 0 idle, 1 calibrating, 2 running; heading is acc/2^15 mod 4096.
    always @(posedge clk) begin : model
        int y;
        int c;
        y = int'($signed(yaw_rt));
        exp_cal_done = 0;
        exp_rdy = 0;
        if (rst) begin
            mode = 0; cal_sum = 0; cal_n = 0; m_offset = 0; m_acc = 0;
            model_valid = 1'b1;
        end else if (strt_cal) begin
            mode = 1; cal_sum = 0; cal_n = 0; m_acc = 0;
        end else if (vld && mode == 1) begin
            cal_sum += y;
            cal_n++;
            if (cal_n == N_CAL) begin
                m_offset = floor_div(cal_sum, N_CAL);
                mode = 2;
                exp_cal_done = 1;
            end
        end else if (vld && mode == 2) begin
            c = y - m_offset;
            if (c > 32767) c = 32767;
            if (c < -32768) c = -32768;
            if (moving) m_acc += c;
            if (lftIR && !rghtIR) m_acc += 512;
            else if (rghtIR && !lftIR) m_acc -= 512;
            m_acc = ((m_acc % MOD) + MOD) % MOD;
            exp_rdy = 1;
        end
        exp_heading = int'(m_acc / 32768);
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check_output("cal_done", int'(cal_done), exp_cal_done);
            check_output("rdy", int'(rdy), exp_rdy);
            check_output("heading", int'(heading), exp_heading);
        end
    end

    initial begin
        rst = 1'b1; strt_cal = 1'b0; vld = 1'b0; yaw_rt = '0;
        moving = 1'b0; lftIR = 1'b0; rghtIR = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_heading", int'(heading), 0);
        check_output("reset_cal_done", int'(cal_done), 0);
        rst = 1'b0;

        // Calibrate at 0x0010; first RUN sample lands in the cal_done cycle.
        apply_stimulus(0, 16'h0000, 0, 0, 0, 1);
        for (int i = 0; i < N_CAL; i++) apply_stimulus(1, 16'h0010, 0, 0, 0, 0);
        apply_stimulus(1, 16'h1010, 1, 0, 0, 0);
        check_output("cal_done_after_256", int'(cal_done), 1);
        check_output("model_offset_0010", m_offset, 16);
        for (int i = 0; i < 7; i++) apply_stimulus(1, 16'h1010, 1, 0, 0, 0);
        apply_stimulus(0, 16'h0000, 0, 0, 0, 0);
        check_output("heading_after_8", int'(heading), 12'h001);

        for (int i = 0; i < 3; i++) apply_stimulus(1, 16'h1010, 0, 0, 0, 0);
        apply_stimulus(0, 16'h0000, 0, 0, 0, 0);
        check_output("not_moving_hold", int'(heading), 12'h001);

        for (int i = 0; i < 64; i++) apply_stimulus(1, 16'h0500, 0, 1, 0, 0);
        apply_stimulus(0, 16'h0000, 0, 0, 0, 0);
        check_output("left_ir", int'(heading), 12'h002);
        for (int i = 0; i < 64; i++) apply_stimulus(1, 16'h0500, 0, 0, 1, 0);
        apply_stimulus(0, 16'h0000, 0, 0, 0, 0);
        check_output("right_ir", int'(heading), 12'h001);
        for (int i = 0; i < 16; i++) apply_stimulus(1, 16'h0500, 0, 1, 1, 0);
        apply_stimulus(0, 16'h0000, 0, 0, 0, 0);
        check_output("both_ir", int'(heading), 12'h001);

        // Zero offset, reach heading 0x123, then restart with a coincident sample.
        apply_stimulus(0, 16'h0000, 0, 0, 0, 1);
        for (int i = 0; i < N_CAL; i++) apply_stimulus(1, 16'h0000, 0, 0, 0, 0);
        for (int i = 0; i < 582; i++) apply_stimulus(1, 16'h4000, 1, 0, 0, 0);
        apply_stimulus(0, 16'h0000, 0, 0, 0, 0);
        check_output("heading_123", int'(heading), 12'h123);
        apply_stimulus(1, 16'h1234, 1, 0, 0, 1);
        apply_stimulus(0, 16'h0000, 0, 0, 0, 0);
        check_output("strt_cal_clears", int'(heading), 12'h000);
        for (int i = 0; i < N_CAL - 1; i++) apply_stimulus(1, 16'h0000, 0, 0, 0, 0);
        apply_stimulus(0, 16'h0000, 0, 0, 0, 0);
        check_output("cal_not_early", int'(cal_done), 0);
        apply_stimulus(1, 16'h0000, 0, 0, 0, 0);
        apply_stimulus(0, 16'h0000, 0, 0, 0, 0);
        check_output("cal_done_one_later", int'(cal_done), 1);

        // 2016 steps of 32767+512 land at 0x7FF; one more crosses to 0x800.
        for (int i = 0; i < 2016; i++) apply_stimulus(1, 16'h7FFF, 1, 1, 0, 0);
        apply_stimulus(0, 16'h0000, 0, 0, 0, 0);
        check_output("before_wrap", int'(heading), 12'h7FF);
        apply_stimulus(1, 16'h7FFF, 1, 1, 0, 0);
        apply_stimulus(0, 16'h0000, 0, 0, 0, 0);
        check_output("wrap_800", int'(heading), 12'h800);

        // Offset 0x7FF0 with sample 0x8000 must saturate to -32768.
        apply_stimulus(0, 16'h0000, 0, 0, 0, 1);
        for (int i = 0; i < N_CAL; i++) apply_stimulus(1, 16'h7FF0, 0, 0, 0, 0);
        apply_stimulus(0, 16'h0000, 0, 0, 0, 0);
        check_output("model_offset_7ff0", m_offset, 32752);
        apply_stimulus(1, 16'h8000, 1, 0, 0, 0);
        apply_stimulus(0, 16'h0000, 0, 0, 0, 0);
        check_output("saturated_comp", int'(heading), 12'hFFF);

        // Reset mid-calibration returns to IDLE, where samples are ignored.
        apply_stimulus(0, 16'h0000, 0, 0, 0, 1);
        for (int i = 0; i < 100; i++) apply_stimulus(1, 16'h0010, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1; vld = 1'b0; strt_cal = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_output("rst_heading", int'(heading), 12'h000);
        check_output("rst_cal_done", int'(cal_done), 0);
        apply_stimulus(1, 16'h0010, 1, 0, 0, 0);
        apply_stimulus(0, 16'h0000, 0, 0, 0, 0);
        check_output("idle_no_rdy", int'(rdy), 0);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
